// File: rtl/color_pkg.sv
// Shared encodings for the colour measurement stage: colour codes, sensor
// filter selects, FSM states and measurement channels.
package color_pkg;

  localparam logic [1:0] COLOR_R = 2'd0;
  localparam logic [1:0] COLOR_G = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;
  localparam logic [1:0] COLOR_Y = 2'd3;

  // {S2,S3} values understood by the TCS3200-style sensor
  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_FILTER,
    ST_SETTLE,
    ST_COUNT,
    ST_CLASSIFY,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CH_RED,
    CH_GREEN,
    CH_BLUE
  } chan_t;

  function automatic logic [1:0] chan_filter(input chan_t ch);
    logic [1:0] f;
    f = FILT_CLEAR;
    case (ch)
      CH_RED:   f = FILT_RED;
      CH_GREEN: f = FILT_GREEN;
      CH_BLUE:  f = FILT_BLUE;
      default:  f = FILT_CLEAR;
    endcase
    return f;
  endfunction

  // Measurement order is red, green, blue; blue is the last channel.
  function automatic chan_t next_chan(input chan_t ch);
    chan_t n;
    n = CH_BLUE;
    case (ch)
      CH_RED:   n = CH_GREEN;
      default:  n = CH_BLUE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/color_detector_edge_sync.sv
// Brings the asynchronous sensor square wave into clk and flags each rising
// edge with a one-cycle pulse.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;

  // two-flop synchronizer followed by a delay flop for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= i_async;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_sync_d;

endmodule

// File: rtl/color_detector.sv
// Colour measurement stage: steps the sensor filter through red, green and
// blue, counts sensor edges over a gate window for each, then classifies.
//
// state         | meaning
// --------------+------------------------------------------------------
// ST_IDLE       | filter on clear, waiting for startDetection
// ST_SET_FILTER | filter driven for current channel, counter/timer cleared
// ST_SETTLE     | sensor output settling after a filter change, edges ignored
// ST_COUNT      | gate window, edges counted (saturating)
// ST_CLASSIFY   | colour code and valid flag computed from stored counts
// ST_DONE       | detectionComplete pulse, filter back to clear
module color_detector
  import color_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 50000,
  parameter int SETTLE_CYCLES = 500,
  parameter int MIN_TOTAL     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startDetection,
  input  logic             sensorFreq,
  output logic [1:0]       filterSelect,
  output logic [CNT_W-1:0] redCount,
  output logic [CNT_W-1:0] greenCount,
  output logic [CNT_W-1:0] blueCount,
  output logic [1:0]       colorCode,
  output logic             colorValid,
  output logic             busy,
  output logic             detectionComplete
);

  localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int SUM_W   = CNT_W + 2;

  state_t           r_state;
  chan_t            r_ch;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_filter;
  logic [CNT_W-1:0] r_red;
  logic [CNT_W-1:0] r_green;
  logic [CNT_W-1:0] r_blue;
  logic [1:0]       r_code;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_rise;
  logic [CNT_W-1:0] w_cnt_next;
  logic [SUM_W-1:0] w_r;
  logic [SUM_W-1:0] w_g;
  logic [SUM_W-1:0] w_b;
  logic [SUM_W-1:0] w_mx;
  logic [SUM_W-1:0] w_mn;
  logic [SUM_W-1:0] w_b15;
  logic [SUM_W-1:0] w_sum;
  logic             w_yellow;
  logic [1:0]       w_code;
  logic             w_valid;

  edge_sync u_edge_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (sensorFreq),
    .o_rise  (w_rise)
  );

  // saturating edge count; an edge on the final gate cycle still lands here
  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise && (r_cnt != {CNT_W{1'b1}}))
      w_cnt_next = r_cnt + CNT_W'(1);
  end

  // classifier: yellow when red and green are both strong and close, else the
  // largest channel with ties going R over G over B
  always_comb begin
    w_r      = SUM_W'(r_red);
    w_g      = SUM_W'(r_green);
    w_b      = SUM_W'(r_blue);
    w_mx     = (w_r >= w_g) ? w_r : w_g;
    w_mn     = (w_r >= w_g) ? w_g : w_r;
    w_b15    = w_b + (w_b >> 1);
    w_sum    = w_r + w_g + w_b;
    w_yellow = (w_mn > w_b15) && ((w_mx - w_mn) <= (w_mx >> 2));
    w_valid  = (32'(w_sum) >= 32'(MIN_TOTAL));
    if (w_yellow)
      w_code = COLOR_Y;
    else if ((w_r >= w_g) && (w_r >= w_b))
      w_code = COLOR_R;
    else if (w_g >= w_b)
      w_code = COLOR_G;
    else
      w_code = COLOR_B;
  end

  // measurement sequencer with its timer, counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ch     <= CH_RED;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_filter <= FILT_CLEAR;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
      r_code   <= COLOR_R;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_filter <= FILT_CLEAR;
          if (startDetection) begin
            r_ch     <= CH_RED;
            r_filter <= chan_filter(CH_RED);
            r_busy   <= 1'b1;
            r_state  <= ST_SET_FILTER;
          end
        end
        ST_SET_FILTER: begin
          r_cnt   <= '0;
          r_timer <= TMR_W'(SETTLE_CYCLES - 1);
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_timer == '0) begin
            r_timer <= TMR_W'(GATE_CYCLES - 1);
            r_state <= ST_COUNT;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_COUNT: begin
          r_cnt <= w_cnt_next;
          if (r_timer == '0) begin
            case (r_ch)
              CH_RED:   r_red   <= w_cnt_next;
              CH_GREEN: r_green <= w_cnt_next;
              default:  r_blue  <= w_cnt_next;
            endcase
            if (r_ch == CH_BLUE) begin
              r_state <= ST_CLASSIFY;
            end else begin
              r_ch     <= next_chan(r_ch);
              r_filter <= chan_filter(next_chan(r_ch));
              r_state  <= ST_SET_FILTER;
            end
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_CLASSIFY: begin
          r_code   <= w_code;
          r_valid  <= w_valid;
          r_done   <= 1'b1;
          r_filter <= FILT_CLEAR;
          r_state  <= ST_DONE;
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign filterSelect      = r_filter;
  assign redCount          = r_red;
  assign greenCount        = r_green;
  assign blueCount         = r_blue;
  assign colorCode         = r_code;
  assign colorValid        = r_valid;
  assign busy              = r_busy;
  assign detectionComplete = r_done;

endmodule

// File: tb/tb_color_detector.sv
// Bench for color_detector: edge-accurate reference counts derived from the
// recorded sensor edges and the documented window timing, classification
// rules evaluated with plain integer arithmetic.
module tb_color_detector;

  localparam int CW     = 8;
  localparam int CW_S   = 4;
  localparam int G      = 100;
  localparam int S      = 4;
  localparam int MT     = 64;
  localparam int CH_LEN = 1 + S + G;
  localparam int LAT    = 3 * CH_LEN + 2;

  logic clk = 1'b0;
  logic reset;
  logic startDetection;
  logic sensorFreq = 1'b0;

  logic [1:0]    filterSelect, filterSelect_s;
  logic [CW-1:0] redCount, greenCount, blueCount;
  logic [CW_S-1:0] redCount_s, greenCount_s, blueCount_s;
  logic [1:0]    colorCode, colorCode_s;
  logic          colorValid, colorValid_s;
  logic          busy, busy_s;
  logic          detectionComplete, detectionComplete_s;

  color_detector #(.CNT_W(CW), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .MIN_TOTAL(MT)) dut (
    .clk(clk), .reset(reset), .startDetection(startDetection), .sensorFreq(sensorFreq),
    .filterSelect(filterSelect), .redCount(redCount), .greenCount(greenCount),
    .blueCount(blueCount), .colorCode(colorCode), .colorValid(colorValid),
    .busy(busy), .detectionComplete(detectionComplete)
  );

  // narrow-counter copy so saturation is reachable within a short gate
  color_detector #(.CNT_W(CW_S), .GATE_CYCLES(G), .SETTLE_CYCLES(S), .MIN_TOTAL(MT)) dut_sat (
    .clk(clk), .reset(reset), .startDetection(startDetection), .sensorFreq(sensorFreq),
    .filterSelect(filterSelect_s), .redCount(redCount_s), .greenCount(greenCount_s),
    .blueCount(blueCount_s), .colorCode(colorCode_s), .colorValid(colorValid_s),
    .busy(busy_s), .detectionComplete(detectionComplete_s)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   s0 = 1000000;
  bit   gen_on = 1'b0;
  int   gen_per[3];
  int   ph = 0;
  int   edge_q[$];
  logic prev_sf = 1'b0;
  logic [1:0] fs_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // cycle counter and record of the posedge index at which each sensor rise is first visible
  initial forever begin
    @(posedge clk);
    cyc++;
    if (sensorFreq && !prev_sf) edge_q.push_back(cyc);
    prev_sf = sensorFreq;
  end

  // sensor square wave, period chosen per channel by elapsed time since start
  initial forever begin
    int rel, ch, per;
    @(negedge clk);
    rel = cyc - s0;
    ch  = (rel < CH_LEN) ? 0 : (rel < 2 * CH_LEN) ? 1 : 2;
    per = gen_per[ch];
    if (!gen_on || per == 0) begin
      sensorFreq = 1'b0;
      ph = 0;
    end else begin
      ph++;
      if (ph >= per) ph = 0;
      sensorFreq = (ph < per / 2);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // edges visible at posedge k are counted in channel c if k falls in its gate window
  function automatic int model_count(input int c, input int cap);
    int a, lo, hi, n;
    a  = c * CH_LEN + 1 + S;
    lo = s0 + a - 1;
    hi = s0 + a + G - 2;
    n  = 0;
    foreach (edge_q[i]) if (edge_q[i] >= lo && edge_q[i] <= hi) n++;
    return (n > cap) ? cap : n;
  endfunction

  function automatic int model_code(input int r, input int g, input int b);
    int mx, mn;
    mx = (r > g) ? r : g;
    mn = (r > g) ? g : r;
    if (mn > b + b / 2 && (mx - mn) * 4 <= mx - (mx % 4)) return 3;
    if (r >= g && r >= b) return 0;
    if (g >= b) return 1;
    return 2;
  endfunction

  task automatic check_results(input string nm);
    int er, eg, eb, sr, sg, sb;
    er = model_count(0, 255); eg = model_count(1, 255); eb = model_count(2, 255);
    sr = model_count(0, 15);  sg = model_count(1, 15);  sb = model_count(2, 15);
    chk({nm, "_red"}, redCount, er);
    chk({nm, "_green"}, greenCount, eg);
    chk({nm, "_blue"}, blueCount, eb);
    chk({nm, "_code"}, colorCode, model_code(er, eg, eb));
    chk({nm, "_valid"}, colorValid, (er + eg + eb >= MT) ? 1 : 0);
    chk({nm, "_sat_red"}, redCount_s, sr);
    chk({nm, "_sat_green"}, greenCount_s, sg);
    chk({nm, "_sat_blue"}, blueCount_s, sb);
    chk({nm, "_sat_code"}, colorCode_s, model_code(sr, sg, sb));
    chk({nm, "_sat_valid"}, colorValid_s, (sr + sg + sb >= MT) ? 1 : 0);
    chk({nm, "_sat_done"}, detectionComplete_s, 1);
  endtask

  task automatic run_meas(input int pr, input int pg, input int pb, input bit extras, input string nm);
    bit got;
    int rel, extra_dc;
    logic [9:0] seq;
    edge_q.delete();
    fs_q.delete();
    gen_per[0] = pr; gen_per[1] = pg; gen_per[2] = pb;
    ph = $urandom_range(0, 39);
    gen_on = 1'b1;
    repeat (3) @(negedge clk);
    fs_q.push_back(filterSelect);
    s0 = cyc + 1;
    startDetection = 1'b1;
    @(posedge clk); #1;
    startDetection = 1'b0;
    chk({nm, "_busy_on"}, busy, 1);
    got = 1'b0;
    rel = 0;
    for (int n = 0; n < LAT + 20 && !got; n++) begin
      rel = cyc - s0;
      if (filterSelect !== fs_q[$]) fs_q.push_back(filterSelect);
      if (detectionComplete === 1'b1) begin
        got = 1'b1;
        chk({nm, "_latency"}, rel + 1, LAT);
        check_results(nm);
      end
      @(negedge clk);
      startDetection = extras && (rel == 40 || rel == 150 || rel == 260 || rel == 315 || rel == 316);
      if (!got) begin
        @(posedge clk); #1;
      end
    end
    chk({nm, "_no_timeout"}, got, 1);
    @(posedge clk); #1;
    startDetection = 1'b0;
    chk({nm, "_pulse_1cyc"}, detectionComplete, 0);
    chk({nm, "_busy_off"}, busy, 0);
    seq = '0;
    for (int i = 0; i < fs_q.size() && i < 5; i++) seq = {seq[7:0], fs_q[i]};
    chk({nm, "_filt_len"}, fs_q.size(), 5);
    chk({nm, "_filt_seq"}, seq, 10'b10_00_11_01_10);
    extra_dc = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (detectionComplete) extra_dc++;
    end
    chk({nm, "_no_extra_dc"}, extra_dc, 0);
    chk({nm, "_idle_busy"}, busy, 0);
    gen_on = 1'b0;
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    startDetection = 1'b0;
    gen_per[0] = 0; gen_per[1] = 0; gen_per[2] = 0;
    repeat (3) @(negedge clk);
    chk("rst_filter", filterSelect, 2'b10);
    chk("rst_red", redCount, 0);
    chk("rst_green", greenCount, 0);
    chk("rst_blue", blueCount, 0);
    chk("rst_code", colorCode, 0);
    chk("rst_valid", colorValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", detectionComplete, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_meas(4, 20, 20, 1'b0, "t1_red");
    run_meas(5, 5, 50, 1'b0, "t2_yellow");
    run_meas(0, 0, 0, 1'b0, "t3_dark");
    run_meas(10, 10, 10, 1'b0, "t4_tie");
    run_meas(40, 4, 40, 1'b0, "t4_green");

    // reset during the green count window
    gen_per[0] = 6; gen_per[1] = 6; gen_per[2] = 6;
    gen_on = 1'b1;
    @(negedge clk);
    s0 = cyc + 1;
    startDetection = 1'b1;
    @(negedge clk);
    startDetection = 1'b0;
    while (cyc - s0 < CH_LEN + 1 + S + 30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_filter", filterSelect, 2'b10);
    chk("t5_rst_red", redCount, 0);
    chk("t5_rst_code", colorCode, 0);
    chk("t5_rst_valid", colorValid, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (LAT + 10) begin
      @(posedge clk); #1;
      if (detectionComplete || busy) seen++;
    end
    chk("t5_no_pulse", seen, 0);
    gen_on = 1'b0;
    run_meas(4, 8, 12, 1'b0, "t5_restart");

    run_meas(7, 9, 11, 1'b1, "t6_extra_start");

    for (int k = 0; k < 3; k++) begin
      run_meas($urandom_range(4, 40), $urandom_range(4, 40), $urandom_range(4, 40),
               k[0], $sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
